// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage MIPS pipeline.
//   Computes LOGIC/SHIFT/ARITH/MOVE results combinationally, owns the HI/LO
//   registers (MTHI/MTLO, single-cycle MULT/MULTU) and runs a 32-step
//   restoring divider that holds the pipeline while it works.
// Ports:
//   clock, reset (async, active-low)
//   ex_operator/ex_category/ex_operand1/ex_operand2/ex_write_addr/ex_write_enable
//     : instruction from the ID/EX buffer
//   mem_write_addr/mem_write_enable/mem_write_data : result to the EX/MEM buffer
//   stall_request : freeze PC, IF/ID and ID/EX this cycle
module ex_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  ex_operator,
    input  logic [2:0]  ex_category,
    input  logic [31:0] ex_operand1,
    input  logic [31:0] ex_operand2,
    input  logic [4:0]  ex_write_addr,
    input  logic        ex_write_enable,
    output logic [4:0]  mem_write_addr,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_data,
    output logic        stall_request
);
    localparam logic [2:0] CAT_LOGIC = 3'd1;
    localparam logic [2:0] CAT_SHIFT = 3'd2;
    localparam logic [2:0] CAT_ARITH = 3'd3;
    localparam logic [2:0] CAT_MOVE  = 3'd4;

    localparam logic [7:0] OP_AND   = 8'h01, OP_OR   = 8'h02, OP_XOR  = 8'h03;
    localparam logic [7:0] OP_NOR   = 8'h04, OP_LUI  = 8'h05;
    localparam logic [7:0] OP_SLL   = 8'h10, OP_SRL  = 8'h11, OP_SRA  = 8'h12;
    localparam logic [7:0] OP_ADDU  = 8'h20, OP_SUBU = 8'h21;
    localparam logic [7:0] OP_SLT   = 8'h22, OP_SLTU = 8'h23;
    localparam logic [7:0] OP_MFHI  = 8'h30, OP_MFLO = 8'h31;
    localparam logic [7:0] OP_MTHI  = 8'h32, OP_MTLO = 8'h33;
    localparam logic [7:0] OP_MULT  = 8'h34, OP_MULTU = 8'h35;
    localparam logic [7:0] OP_DIV   = 8'h36, OP_DIVU = 8'h37;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [31:0] hi, lo;
    logic [1:0]  state;
    logic [4:0]  div_cnt;
    logic [31:0] div_quo;     // dividend shifts out the top, quotient bits shift in
    logic [31:0] div_rem;
    logic [31:0] div_dvs;
    logic        neg_quo, neg_rem;

    logic        is_div, div_signed;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] rem_shift, trial;
    logic [31:0] quo_final, rem_final;
    logic [63:0] prod_s, prod_u;
    logic [4:0]  shamt;
    logic [31:0] alu_result;

    assign is_div     = (ex_operator == OP_DIV) || (ex_operator == OP_DIVU);
    assign div_signed = (ex_operator == OP_DIV);
    assign a_neg      = div_signed & ex_operand1[31];
    assign b_neg      = div_signed & ex_operand2[31];
    assign a_mag      = a_neg ? (32'd0 - ex_operand1) : ex_operand1;
    assign b_mag      = b_neg ? (32'd0 - ex_operand2) : ex_operand2;

    // One restoring step: a negative trial (bit 32 set) keeps the old remainder.
    assign rem_shift  = {div_rem, div_quo[31]};
    assign trial      = rem_shift - {1'b0, div_dvs};
    assign quo_final  = neg_quo ? (32'd0 - div_quo) : div_quo;
    assign rem_final  = neg_rem ? (32'd0 - div_rem) : div_rem;

    assign prod_s = $signed({{32{ex_operand1[31]}}, ex_operand1}) *
                    $signed({{32{ex_operand2[31]}}, ex_operand2});
    assign prod_u = {32'd0, ex_operand1} * {32'd0, ex_operand2};
    assign shamt  = ex_operand1[4:0];

    always_comb begin
        alu_result = '0;
        case (ex_category)
            CAT_LOGIC: case (ex_operator)
                OP_AND:  alu_result = ex_operand1 & ex_operand2;
                OP_OR:   alu_result = ex_operand1 | ex_operand2;
                OP_XOR:  alu_result = ex_operand1 ^ ex_operand2;
                OP_NOR:  alu_result = ~(ex_operand1 | ex_operand2);
                OP_LUI:  alu_result = {ex_operand2[15:0], 16'h0};
                default: alu_result = '0;
            endcase
            CAT_SHIFT: case (ex_operator)
                OP_SLL:  alu_result = ex_operand2 << shamt;
                OP_SRL:  alu_result = ex_operand2 >> shamt;
                OP_SRA:  alu_result = $signed(ex_operand2) >>> shamt;
                default: alu_result = '0;
            endcase
            CAT_ARITH: case (ex_operator)
                OP_ADDU: alu_result = ex_operand1 + ex_operand2;
                OP_SUBU: alu_result = ex_operand1 - ex_operand2;
                OP_SLT:  alu_result = {31'd0, $signed(ex_operand1) < $signed(ex_operand2)};
                OP_SLTU: alu_result = {31'd0, ex_operand1 < ex_operand2};
                default: alu_result = '0;
            endcase
            CAT_MOVE: case (ex_operator)
                OP_MFHI: alu_result = hi;
                OP_MFLO: alu_result = lo;
                default: alu_result = '0;
            endcase
            default: alu_result = '0;
        endcase
    end

    // Gated by reset so the pipeline sees no stall/write while reset is held.
    assign stall_request    = reset & (((state == ST_IDLE) & is_div) | (state == ST_BUSY));
    assign mem_write_enable = reset & ex_write_enable & ~stall_request;
    assign mem_write_addr   = ex_write_addr;
    assign mem_write_data   = alu_result;

    // Divider FSM; operands are captured at issue so later input changes are ignored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            div_quo <= '0;
            div_rem <= '0;
            div_dvs <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (is_div) begin
                    div_cnt <= '0;
                    if (ex_operand2 == 32'd0) begin
                        div_quo <= 32'hFFFF_FFFF;
                        div_rem <= ex_operand1;
                        neg_quo <= 1'b0;
                        neg_rem <= 1'b0;
                        state   <= ST_DONE;
                    end else begin
                        div_quo <= a_mag;
                        div_rem <= '0;
                        div_dvs <= b_mag;
                        neg_quo <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!trial[32]) begin
                        div_rem <= trial[31:0];
                        div_quo <= {div_quo[30:0], 1'b1};
                    end else begin
                        div_rem <= rem_shift[31:0];
                        div_quo <= {div_quo[30:0], 1'b0};
                    end
                    div_cnt <= div_cnt + 5'd1;
                    if (div_cnt == 5'd31) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == ST_DONE) begin
            hi <= rem_final;
            lo <= quo_final;
        end else begin
            case (ex_operator)
                OP_MTHI:  hi <= ex_operand1;
                OP_MTLO:  lo <= ex_operand1;
                OP_MULT:  {hi, lo} <= prod_s;
                OP_MULTU: {hi, lo} <= prod_u;
                default: ;
            endcase
        end
    end
endmodule
